dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 12: byte-address bits decoded, giving 2^ADDR_WIDTH bytes of storage.
REQ-002 SHALL have parameter WAIT_CYCLES, default 2: wait states between request accept and response, legal range 0-15.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port req_valid, input, 1: initiator presents a request.
REQ-006 SHALL have port req_ready, output, 1: responder can accept a request.
REQ-007 SHALL have port req_write, input, 1: 1 = store, 0 = load.
REQ-008 SHALL have port req_addr, input, 32: byte address.
REQ-009 SHALL have port req_wdata, input, 32: store data, right-aligned.
REQ-010 SHALL have port req_size, input, 3: funct3 encoding; 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-011 SHALL have port rsp_valid, output, 1: response available.
REQ-012 SHALL have port rsp_ready, input, 1: initiator accepts the response.
REQ-013 SHALL have port rsp_rdata, output, 32: load data, extended per req_size; 0 for stores.
REQ-014 SHALL have port rsp_err, output, 1: access error flag, qualified by rsp_valid.

Function
REQ-015 SHALL implement a three-state FSM: IDLE, WAIT, RESP.
REQ-016 SHALL drive req_ready = 1 only in IDLE with rst high.
REQ-017 SHALL accept a request on a clock edge where req_valid && req_ready, latching write, addr, wdata and size.
REQ-018 SHALL transition IDLE->WAIT on accept and load the wait counter with WAIT_CYCLES; if WAIT_CYCLES == 0, SHALL go IDLE->RESP directly.
REQ-019 SHALL decrement the counter in WAIT and go to RESP on the edge where it reaches 0, so rsp_valid rises exactly 1+WAIT_CYCLES cycles after the accept edge.
REQ-020 SHALL commit a store to storage, and capture load data, on the edge entering RESP, never earlier.
REQ-021 SHALL hold rsp_valid, rsp_rdata and rsp_err stable in RESP until rsp_ready is high, then return to IDLE on that edge.
REQ-022 SHALL allow rsp_ready to be high before rsp_valid; a response is consumed on its first cycle when rsp_ready is already high.
REQ-023 SHALL have at most one transaction outstanding; minimum period is 2+WAIT_CYCLES cycles per transaction.
REQ-024 SHALL store little-endian: B writes byte lane addr[1:0]; H writes lanes addr[1]*2 and +1; W writes all four lanes.
REQ-025 SHALL sign-extend loads for sizes 000 and 001, and zero-extend for 100 and 101.
REQ-026 SHALL index storage with req_addr[ADDR_WIDTH-1:0]; upper address bits are ignored, so accesses wrap modulo 2^ADDR_WIDTH.
REQ-027 SHALL treat size code 010 with any store as full-word; stores with 100/101 SHALL behave as 000/001.
REQ-028 SHALL ignore req_valid and all request inputs outside IDLE.

Reset
REQ-029 SHALL, while rst is low, force state IDLE, counter 0, rsp_valid 0, rsp_rdata 0, rsp_err 0 and req_ready 0.
REQ-030 SHALL, on reset mid-transaction, drop the pending transaction; an uncommitted store SHALL NOT modify storage.
REQ-031 SHALL leave storage contents unaffected by reset.

Configuration
REQ-032 SHALL, with DMEM_MISALIGN_CHECK_EN defined, set rsp_err = 1, suppress the store and return rsp_rdata = 0 for: H/HU with addr[0] = 1, W with addr[1:0] != 00, or size codes 011, 110 and 111; latency is unchanged.
REQ-033 SHALL, without DMEM_MISALIGN_CHECK_EN, tie rsp_err to 0, align H to addr[ADDR_WIDTH-1:1] and W to addr[ADDR_WIDTH-1:2], and treat reserved size codes as W.

Verification
REQ-034 SHALL cover: WAIT_CYCLES=2, store W 0xDEADBEEF at 0x010, then load W at 0x010 -> rsp_valid rises 3 cycles after each accept; rdata 0xDEADBEEF.
REQ-035 SHALL cover: after REQ-034, load B at 0x013 -> 0xFFFFFFDE; load BU at 0x013 -> 0x000000DE; load HU at 0x010 -> 0x0000BEEF.
REQ-036 SHALL cover: rsp_ready held low 5 cycles during a response -> rsp_valid/rdata stable; req_ready stays 0 and a new req_valid is ignored.
REQ-037 SHALL cover: rst pulsed low in WAIT of a store of 0x12345678 to 0x020 -> rsp_valid never asserts; a later load at 0x020 returns the prior contents.
REQ-038 SHALL cover: ADDR_WIDTH=12, store W 0xA5A5A5A5 at 0x00001004 -> load at 0x004 returns 0xA5A5A5A5.
REQ-039 SHALL cover: with DMEM_MISALIGN_CHECK_EN, store W at 0x002 -> rsp_err = 1 and storage unchanged; without the macro -> rsp_err = 0 and word 0x000 written.

Source files
------------

// File: rtl/dmem_responder.sv
// Single-port data-memory responder: one request at a time, fixed wait states, little-endian byte lanes.
// Optional alignment/size checking is enabled with `define DMEM_MISALIGN_CHECK_EN.
module dmem_responder #(
    parameter int ADDR_WIDTH  = 12,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_size,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int DEPTH  = 2 ** (ADDR_WIDTH - 2);
    localparam bit BYPASS = (WAIT_CYCLES == 0);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t                  state_q;
    logic [3:0]              cnt_q;
    logic                    rsp_valid_q;
    logic [31:0]             rsp_rdata_q;
    logic                    rsp_err_q;

    logic                    write_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [31:0]             wdata_q;
    logic [2:0]              size_q;

    logic [31:0]             mem_q [DEPTH];

    logic                    accept;
    logic                    enter_resp;
    logic                    op_write;
    logic [ADDR_WIDTH-1:0]   op_addr;
    logic [31:0]             op_wdata;
    logic [2:0]              op_size;
    logic [ADDR_WIDTH-3:0]   word_idx;
    logic [31:0]             rd_word;
    logic [1:0]              lane;
    logic [3:0]              be_d;
    logic [31:0]             wlanes_d;
    logic [31:0]             ld_d;
    logic                    err_d;
    logic [7:0]              byte_v;
    logic [15:0]             half_v;
    logic                    we;
    logic                    unused_addr_hi;

    assign unused_addr_hi = ^req_addr[31:ADDR_WIDTH];

    assign req_ready  = rst && (state_q == S_IDLE);
    assign accept     = req_valid && req_ready;
    assign enter_resp = (state_q == S_WAIT && cnt_q == 4'd1) || (BYPASS && accept);

    // With zero wait states the commit edge is the accept edge, so work from the live inputs.
    assign op_write = BYPASS ? req_write                  : write_q;
    assign op_addr  = BYPASS ? req_addr[ADDR_WIDTH-1:0]   : addr_q;
    assign op_wdata = BYPASS ? req_wdata                  : wdata_q;
    assign op_size  = BYPASS ? req_size                   : size_q;

    assign word_idx = op_addr[ADDR_WIDTH-1:2];
    assign rd_word  = mem_q[word_idx];
    assign lane     = op_addr[1:0];

    always_comb begin
        be_d     = 4'b0000;
        wlanes_d = 32'd0;
        ld_d     = 32'd0;
        err_d    = 1'b0;
        byte_v   = rd_word[{lane, 3'b000} +: 8];
        half_v   = op_addr[1] ? rd_word[31:16] : rd_word[15:0];
        case (op_size[1:0])
            2'b00: begin
                be_d     = 4'b0001 << lane;
                wlanes_d = {4{op_wdata[7:0]}};
                ld_d     = {{24{byte_v[7] & ~op_size[2]}}, byte_v};
            end
            2'b01: begin
                be_d     = op_addr[1] ? 4'b1100 : 4'b0011;
                wlanes_d = {2{op_wdata[15:0]}};
                ld_d     = {{16{half_v[15] & ~op_size[2]}}, half_v};
            end
            default: begin
                be_d     = 4'b1111;
                wlanes_d = op_wdata;
                ld_d     = rd_word;
            end
        endcase
`ifdef DMEM_MISALIGN_CHECK_EN
        err_d = (op_size[1:0] == 2'b01 && op_addr[0])
             || (op_size == 3'b010 && op_addr[1:0] != 2'b00)
             || (op_size == 3'b011)
             || (op_size[2:1] == 2'b11);
`endif
    end

    assign we = enter_resp && op_write && !err_d;

    always_ff @(posedge clk) begin
        if (accept) begin
            write_q <= req_write;
            addr_q  <= req_addr[ADDR_WIDTH-1:0];
            wdata_q <= req_wdata;
            size_q  <= req_size;
        end
    end

    // Storage has no reset; a store lands only on the edge that enters RESP.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be_d[i]) mem_q[word_idx][8*i +: 8] <= wlanes_d[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        state_q <= BYPASS ? S_RESP : S_WAIT;
                        cnt_q   <= 4'(WAIT_CYCLES);
                    end
                end
                S_WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        state_q     <= S_IDLE;
                        rsp_valid_q <= 1'b0;
                        rsp_rdata_q <= 32'd0;
                        rsp_err_q   <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
            if (enter_resp) begin
                state_q     <= S_RESP;
                cnt_q       <= 4'd0;
                rsp_valid_q <= 1'b1;
                rsp_err_q   <= err_d;
                rsp_rdata_q <= (op_write || err_d) ? 32'd0 : ld_d;
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed plus randomized checks of dmem_responder against a byte-array reference model.
module tb_dmem_responder;

    localparam int AW   = 12;
    localparam int WC   = 2;
    localparam int MEMB = 1 << AW;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_size;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int total = 0;
    int bad   = 0;

    logic [7:0] ref_mem [0:MEMB-1];

    dmem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(WC)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_size  (req_size),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Byte-addressed memory semantics: wrap, size, alignment, extension.
    function automatic void model(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                                  input logic [2:0] sz, output logic [31:0] rd, output logic err);
        int n;
        int a;
        logic [31:0] v;
        a   = int'(addr % MEMB);
        n   = (sz[1:0] == 2'b00) ? 1 : (sz[1:0] == 2'b01) ? 2 : 4;
        err = 1'b0;
        rd  = 32'd0;
`ifdef DMEM_MISALIGN_CHECK_EN
        if (sz == 3'b011 || sz == 3'b110 || sz == 3'b111 || (a % n) != 0) err = 1'b1;
`else
        a = a - (a % n);
`endif
        if (err) return;
        if (wr) begin
            for (int k = 0; k < n; k++) ref_mem[a + k] = wd[8*k +: 8];
        end else begin
            v = 32'd0;
            for (int k = 0; k < n; k++) v = v | (32'(ref_mem[a + k]) << (8 * k));
            if (!sz[2] && n < 4 && v[8*n-1]) v = v - (32'd1 << (8 * n));
            rd = v;
        end
    endfunction

    task automatic txn(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [2:0] sz, input int hold, input bit junk,
                       output logic [31:0] obs_d, output logic obs_e);
        logic [31:0] exp_d;
        logic        exp_e;
        int          n;
        int          lat;
        model(wr, addr, wd, sz, exp_d, exp_e);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wd;
        req_size  = sz;
        rsp_ready = (hold == 0);
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("accept_timeout", 32'(n < 50), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_write = 1'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_size  = 3'($urandom);
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("rsp_latency", 32'(lat), 32'(1 + WC));
        chk("rsp_rdata", rsp_rdata, exp_d);
        chk("rsp_err", 32'(rsp_err), 32'(exp_e));
        obs_d = rsp_rdata;
        obs_e = rsp_err;
        for (int i = 0; i < hold; i++) begin
            if (junk) begin
                req_valid = 1'b1;
                req_write = 1'b1;
                req_addr  = addr;
                req_wdata = ~wd;
                req_size  = 3'b010;
            end
            @(negedge clk);
            chk("hold_valid", 32'(rsp_valid), 32'd1);
            chk("hold_rdata", rsp_rdata, exp_d);
            chk("hold_ready", 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        if (hold > 0) begin
            @(negedge clk);
        end else begin
            @(negedge clk);
        end
        chk("rsp_consumed", 32'(rsp_valid), 32'd0);
        rsp_ready = 1'b0;
    endtask

    logic [31:0] od;
    logic        oe;
    logic [31:0] tmp;

    initial begin
        rst       = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = 32'd0;
        req_wdata = 32'd0;
        req_size  = 3'd0;
        rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        chk("rst_err", 32'(rsp_err), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", 32'(req_ready), 32'd1);

        for (int w = 0; w < 64; w++) txn(1'b1, 32'(w * 4), $urandom, 3'b010, 0, 1'b0, od, oe);

        txn(1'b1, 32'h010, 32'hDEADBEEF, 3'b010, 0, 1'b0, od, oe);
        txn(1'b0, 32'h010, 32'h0, 3'b010, 0, 1'b0, od, oe);
        chk("ld_w_deadbeef", od, 32'hDEADBEEF);
        txn(1'b0, 32'h013, 32'h0, 3'b000, 1, 1'b0, od, oe);
        chk("ld_b_signed", od, 32'hFFFFFFDE);
        txn(1'b0, 32'h013, 32'h0, 3'b100, 0, 1'b0, od, oe);
        chk("ld_bu", od, 32'h000000DE);
        txn(1'b0, 32'h010, 32'h0, 3'b101, 2, 1'b0, od, oe);
        chk("ld_hu", od, 32'h0000BEEF);

        txn(1'b0, 32'h010, 32'h0, 3'b010, 5, 1'b1, od, oe);
        repeat (5) begin
            @(negedge clk);
            chk("no_ghost_rsp", 32'(rsp_valid), 32'd0);
        end
        txn(1'b0, 32'h010, 32'h0, 3'b010, 0, 1'b0, od, oe);
        chk("ghost_store_dropped", od, 32'hDEADBEEF);

        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h020;
        req_wdata = 32'h12345678;
        req_size  = 3'b010;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("midrst_ready", 32'(req_ready), 32'd0);
        chk("midrst_valid", 32'(rsp_valid), 32'd0);
        chk("midrst_rdata", rsp_rdata, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("midrst_no_rsp", 32'(rsp_valid), 32'd0);
        end
        tmp = {ref_mem[35], ref_mem[34], ref_mem[33], ref_mem[32]};
        txn(1'b0, 32'h020, 32'h0, 3'b010, 0, 1'b0, od, oe);
        chk("midrst_prior", od, tmp);

        txn(1'b1, 32'h00001004, 32'hA5A5A5A5, 3'b010, 0, 1'b0, od, oe);
        txn(1'b0, 32'h004, 32'h0, 3'b010, 0, 1'b0, od, oe);
        chk("wrap_ld", od, 32'hA5A5A5A5);

        txn(1'b1, 32'h002, 32'h11223344, 3'b010, 0, 1'b0, od, oe);
`ifdef DMEM_MISALIGN_CHECK_EN
        chk("misalign_err", 32'(oe), 32'd1);
`else
        chk("misalign_err", 32'(oe), 32'd0);
`endif
        txn(1'b0, 32'h000, 32'h0, 3'b010, 0, 1'b0, od, oe);

        for (int t = 0; t < 60; t++) begin
            txn(1'($urandom), $urandom & 32'hFFFF_F0FF, $urandom, 3'($urandom),
                int'($urandom_range(0, 3)), 1'($urandom), od, oe);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
